// File: rtl/mul16_rr_seq.sv
// Shift-and-add 16x16 unsigned multiplier shared by two round-robin requesters.
// One adder pass per multiplier bit; results leave on a tagged valid/ready channel.
module mul16_rr_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_product,
    output logic        rsp_id,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state_reg, state_next;
    logic [32:0] p_reg;
    logic [15:0] mcand_reg;
    logic [3:0]  cnt_reg;
    logic        id_reg;
    logic        last_id_reg;

    logic        grant;
    logic        accept;
    logic [1:0]  valid_vec;
    logic [1:0]  ready_vec;
    logic [16:0] hi;

    // Contention goes to whichever requester was not served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_id_reg;
        else if (req1_valid)
            grant = 1'b1;
    end

    assign valid_vec = {req1_valid, req0_valid};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = (state_reg == IDLE) && (grant == 1'(gi)) && valid_vec[gi];
        end
    endgenerate

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];
    assign accept     = |ready_vec;

    assign hi = p_reg[32:16] + (p_reg[0] ? {1'b0, mcand_reg} : 17'd0);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = MUL;
            MUL:     if (cnt_reg == 4'd15) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            p_reg       <= '0;
            mcand_reg   <= '0;
            cnt_reg     <= '0;
            id_reg      <= 1'b0;
            last_id_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        mcand_reg <= grant ? req1_a : req0_a;
                        p_reg     <= {17'd0, (grant ? req1_b : req0_b)};
                        id_reg    <= grant;
                        cnt_reg   <= '0;
                    end
                end
                MUL: begin
                    p_reg   <= {1'b0, hi, p_reg[15:1]};
                    cnt_reg <= cnt_reg + 4'd1;
                end
                DONE: begin
                    if (rsp_ready) last_id_reg <= id_reg;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid   = (state_reg == DONE);
    assign rsp_product = (state_reg == DONE) ? p_reg[31:0] : 32'd0;
    assign rsp_id      = (state_reg == DONE) ? id_reg : 1'b0;
    assign busy        = (state_reg != IDLE);
endmodule

// File: doc/mul16_rr_seq.md
# mul16_rr_seq

Time-multiplexed 16x16 unsigned multiplier with its own sequencer. It shares one 16-bit adder stage between two requesters: each product needs one adder pass per multiplier bit, so a product takes 16 cycles. Requesters are arbitrated round-robin and each result is returned on a single valid/ready response channel tagged with the requester ID. It is the low-area alternative to the fully unrolled 15-adder array multiplier.

## Interface
- Parameters: none. Width is fixed at 16x16 -> 32.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0's pair is accepted this cycle.
- req0_a, req0_b  in  16 each  requester 0 operands (unsigned).
- req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_product  out  32  A*B.
- rsp_id  out  1  requester that issued the operands.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, MUL, DONE.
- **IDLE, grant selection:**
  - Only one valid request: grant it.
  - Both valid: grant the requester that is not `last_id`.
  - `last_id` resets to 1, so requester 0 wins the first contention.
- **IDLE, ready:** `reqN_ready = (state==IDLE) & grant==N & reqN_valid`. Ready is combinational from the valids; requesters must not make valid depend on ready.
- **IDLE, accept:** on an accept handshake:
  - latch A into `mcand[15:0]`;
  - load `P[32:0] = {17'b0, B}`;
  - latch the ID; clear `cnt[3:0]`;
  - go to MUL.
- **MUL, each cycle:**
  - `hi[16:0] = P[32:16] + (P[0] ? {1'b0,mcand} : 17'b0)`, a 16-bit add with carry-out in bit 16;
  - `P <= {1'b0, hi, P[15:1]}`;
  - `cnt <= cnt+1`;
  - when `cnt==15`, go to DONE.
- **DONE:**
  - `rsp_valid=1`, `rsp_product=P[31:0]`, `rsp_id` = latched ID;
  - all three hold stable until `rsp_ready`;
  - on handshake: `last_id <= ID`, go to IDLE.
- **Request side:**
  - No request is accepted in MUL or DONE; both readies are 0.
  - Operands only need to be valid in the accept cycle.
  - Dropping valid before grant is legal; nothing is captured.
- **Arithmetic:** exact unsigned product; no overflow is possible (max 0xFFFF*0xFFFF = 0xFFFE_0001). `P[32]` is always 0 at DONE.

## Timing
- **Reset (rst_n low at a clock edge):**
  - state=IDLE, `P=0`, `mcand=0`, `cnt=0`, `last_id=1`;
  - `rsp_valid=0`, `rsp_product=0`, `rsp_id=0`, `busy=0`;
  - `req0_ready` and `req1_ready` depend only on the valids; 0 if no valid.
- **Reset mid-operation:** the in-flight product is discarded with no response emitted. The first post-reset cycle is IDLE and can accept.
- **Latency:**
  - accept in cycle T;
  - MUL occupies cycles T+1..T+16;
  - `rsp_valid` rises in T+17.
- **Throughput:** with `rsp_ready` held high, the response handshake is in T+17, IDLE in T+18, and the next accept at the earliest in T+18. That gives one product per 18 cycles.
- **Backpressure:** `rsp_ready` low holds DONE indefinitely. `busy` stays 1 and both readies stay 0.
- **Round-robin update:** `last_id` updates only on the response handshake. A requester that keeps valid high is served at most every other grant while the other is also requesting.

## Test plan
- **Single request:** reset, then req0 with a=0x1234, b=0x5678 -> accepted in the first IDLE cycle; rsp_valid exactly 17 cycles later with rsp_product=0x0626_0060, rsp_id=0.
- **Corners:** a=0xFFFF, b=0xFFFF -> 0xFFFE_0001. Also a=0, b=0xFFFF -> 0 and a=0xFFFF, b=1 -> 0x0000_FFFF.
- **Contention:** req0 and req1 both held valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1. Each response carries the matching ID and correct product; accepts are spaced 18 cycles apart.
- **Backpressure:** hold rsp_ready=0 for 10 cycles after rsp_valid -> product and ID stable, both readies 0, busy=1. Raise rsp_ready -> one handshake, then IDLE.
- **Reset mid-MUL:** assert rst_n=0 at MUL cycle 8 -> next cycle all outputs at reset values and no rsp_valid. A fresh request then completes correctly with requester 0 winning contention.
